// File: rtl/vending_if.sv
// ---------------------------------------------------------------------------
// vending_if : coin / dispense bundle between the coin-acceptor front end,
//              the vending controller and the dispense/change actuators.
//
//   coinn   [1:0]  coin code (00 none, 01 = 5, 10 = 10, 11 = 20 if enabled)
//   out            one-cycle dispense pulse
//   changee [1:0]  change code valid with out (00 none, 01 = 5, 10 = 10, 11 = 15)
//
// Modports:
//   master : coin source / actuator side (drives coinn, observes the response)
//   slave  : vending controller side (samples coinn, drives out/changee)
// ---------------------------------------------------------------------------
interface vending_if;
  logic [1:0] coinn;
  logic       out;
  logic [1:0] changee;

  modport master (output coinn, input out, input changee);
  modport slave  (input coinn, output out, output changee);
endinterface

// File: rtl/vending.sv
// ---------------------------------------------------------------------------
// vending : single-product vending controller, price 15.
//
// Accepts one coin per clock, tracks credit as 0/5/10 and, on the edge where
// the credit reaches 15 or more, pulses out for one cycle together with the
// change code for any excess. Outputs are registered: the response to a coin
// becomes visible one clock after it is sampled.
//
// Ports:
//   clk    : system clock, rising edge active
//   reset  : asynchronous active-low reset; clears credit and outputs
//   bus    : vending_if.slave (coinn in, out / changee out)
//
// Build option:
//   VENDING_COIN20_EN : when defined, coin code 11 is worth 20 and always
//                       completes a sale with change 5/10/15 from S0/S5/S10.
//                       When undefined, coin code 11 is rejected (state held,
//                       no dispense, no change) and change 11 never occurs.
// ---------------------------------------------------------------------------
module vending (
  input  logic     clk,
  input  logic     reset,
  vending_if.slave bus
);

  // Credit held between coins; the fourth encoding is unused and recovers
  // to S0 on the next edge.
  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [1:0] CHG_NONE  = 2'b00;
  localparam logic [1:0] CHG_5     = 2'b01;
  localparam logic [1:0] CHG_10    = 2'b10;
  localparam logic [1:0] CHG_15    = 2'b11;

  state_t     state_q, state_d;
  logic       out_q, out_d;
  logic [1:0] chg_q, chg_d;

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    // The defaults also encode "no sale this edge": out low, no change.
    state_d = state_q;
    out_d   = 1'b0;
    chg_d   = CHG_NONE;

    case (state_q)
      S0: begin
        case (bus.coinn)
          COIN_5:  state_d = S5;
          COIN_10: state_d = S10;
          COIN_20: begin
`ifdef VENDING_COIN20_EN
            state_d = S0;
            out_d   = 1'b1;
            chg_d   = CHG_5;
`else
            // Rejected coin: the acceptor returns it, credit is unchanged.
            state_d = state_q;
`endif
          end
          default: state_d = state_q;
        endcase
      end

      S5: begin
        case (bus.coinn)
          COIN_5:  state_d = S10;
          COIN_10: begin
            state_d = S0;
            out_d   = 1'b1;
          end
          COIN_20: begin
`ifdef VENDING_COIN20_EN
            state_d = S0;
            out_d   = 1'b1;
            chg_d   = CHG_10;
`else
            state_d = state_q;
`endif
          end
          default: state_d = state_q;
        endcase
      end

      S10: begin
        case (bus.coinn)
          COIN_5: begin
            state_d = S0;
            out_d   = 1'b1;
          end
          COIN_10: begin
            state_d = S0;
            out_d   = 1'b1;
            chg_d   = CHG_5;
          end
          COIN_20: begin
`ifdef VENDING_COIN20_EN
            state_d = S0;
            out_d   = 1'b1;
            chg_d   = CHG_15;
`else
            state_d = state_q;
`endif
          end
          default: state_d = state_q;
        endcase
      end

      // Unused encoding: recover to S0 without dispensing.
      default: state_d = S0;
    endcase
  end

  // State and registered outputs. Because out/changee are written on every
  // edge, an edge that does not complete a sale clears them, which makes out
  // a single-cycle pulse and lets a coin right after a sale start from S0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
      out_q   <= 1'b0;
      chg_q   <= CHG_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      out_q   <= out_d;
      chg_q   <= chg_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.changee = chg_q;

  // COIN_NONE documents the idle code handled by the case defaults above.
  logic unused_ok;
  assign unused_ok = &{1'b0, COIN_NONE};

endmodule

// File: tb/tb_vending.sv
// ---------------------------------------------------------------------------
// tb_vending : self-checking bench for the vending controller.
//
// The stimulus thread applies one coin per clock and pushes the expected
// {out, changee} for that edge into a queue; a monitor samples the DUT 1 ns
// after each rising edge and pops/compares whenever an expectation is
// pending. Asynchronous-reset effects are checked directly between edges.
// Define VENDING_COIN20_EN for both RTL and bench to cover the 20-coin build.
// ---------------------------------------------------------------------------
module tb_vending;

  logic clk;
  logic reset;

  vending_if bus ();

  vending u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] resp;   // {out, changee}
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [2:0] act, input logic [2:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got out=%b changee=%b, expected out=%b changee=%b",
               tag, act[2], act[1:0], want[2], want[1:0]);
    end
  endtask

  // Drive a coin for the next rising edge and record the expected response.
  task automatic apply(input logic [1:0] coin, input logic o, input logic [1:0] chg,
                       input string tag);
    exp_t e;
    @(negedge clk);
    bus.coinn = coin;
    e.tag  = tag;
    e.resp = {o, chg};
    exp_q.push_back(e);
  endtask

  // Monitor: compare the registered response one step after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, {bus.out, bus.changee}, e.resp);
      end
    end
  end

  // Pulse reset low between edges, right after the next sampling edge, and
  // check that the outputs clear without waiting for a clock.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check(tag, {bus.out, bus.changee}, 3'b000);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int budget;
    bus.coinn = 2'b00;
    reset     = 1'b1;
    #1;
    reset     = 1'b0;
    #1;
    check("async_reset_at_start", {bus.out, bus.changee}, 3'b000);

    // Coins offered while reset is held must be ignored.
    apply(2'b10, 1'b0, 2'b00, "rst_hold_0");
    apply(2'b10, 1'b0, 2'b00, "rst_hold_1");
    apply(2'b10, 1'b0, 2'b00, "rst_hold_2");
    @(negedge clk);
    bus.coinn = 2'b00;
    reset     = 1'b1;

    // No credit survived reset: 5 + 10 sells exactly on the second coin.
    apply(2'b01, 1'b0, 2'b00, "post_rst_5");
    apply(2'b10, 1'b1, 2'b00, "post_rst_sale");

    // Exact price with three 5s; out must drop the cycle after.
    apply(2'b01, 1'b0, 2'b00, "exact_5a");
    apply(2'b01, 1'b0, 2'b00, "exact_5b");
    apply(2'b01, 1'b1, 2'b00, "exact_sale");
    apply(2'b00, 1'b0, 2'b00, "exact_pulse_end");

    // Overpay 10 + 10 -> change 5, back to S0.
    apply(2'b10, 1'b0, 2'b00, "over_10a");
    apply(2'b10, 1'b1, 2'b01, "over_sale");
    apply(2'b01, 1'b0, 2'b00, "over_then_5");
    apply(2'b10, 1'b1, 2'b00, "s5_plus_10");

    // Idle gaps keep credit.
    apply(2'b01, 1'b0, 2'b00, "idle_5");
    apply(2'b00, 1'b0, 2'b00, "idle_gap_a");
    apply(2'b00, 1'b0, 2'b00, "idle_gap_b");
    apply(2'b10, 1'b1, 2'b00, "idle_sale");

    // Back-to-back sales: coin right after a sale is credited from S0.
    apply(2'b10, 1'b0, 2'b00, "b2b_10");
    apply(2'b01, 1'b1, 2'b00, "b2b_sale_a");
    apply(2'b10, 1'b0, 2'b00, "b2b_next_10");
    apply(2'b10, 1'b1, 2'b01, "b2b_sale_b");

    // Async reset clears a visible sale pulse immediately.
    apply(2'b10, 1'b0, 2'b00, "rst_sale_10a");
    apply(2'b10, 1'b1, 2'b01, "rst_sale_pulse");
    reset_pulse("async_clear_pulse");

    // Async reset mid-transaction discards credit of 10.
    apply(2'b10, 1'b0, 2'b00, "mid_10");
    reset_pulse("async_clear_mid");
    apply(2'b01, 1'b0, 2'b00, "mid_after_5a");
    apply(2'b01, 1'b0, 2'b00, "mid_after_5b");
    apply(2'b01, 1'b1, 2'b00, "mid_after_sale");

    // Coin code 11.
    apply(2'b10, 1'b0, 2'b00, "c20_setup_10");
`ifdef VENDING_COIN20_EN
    apply(2'b11, 1'b1, 2'b11, "c20_from_s10");
    apply(2'b01, 1'b0, 2'b00, "c20_then_5");
    apply(2'b11, 1'b1, 2'b10, "c20_from_s5");
    apply(2'b11, 1'b1, 2'b01, "c20_from_s0");
`else
    apply(2'b11, 1'b0, 2'b00, "c20_reject_s10");
    apply(2'b01, 1'b1, 2'b00, "c20_held_s10_sale");
    apply(2'b11, 1'b0, 2'b00, "c20_reject_s0");
    apply(2'b01, 1'b0, 2'b00, "c20_held_s0_5");
    apply(2'b11, 1'b0, 2'b00, "c20_reject_s5");
    apply(2'b10, 1'b1, 2'b00, "c20_held_s5_sale");
`endif

    @(negedge clk);
    bus.coinn = 2'b00;

    // Bounded drain of pending expectations.
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d expected pending=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
